// File: rtl/elevador_cabina_if.sv
// Cabin <-> controller bundle.
// The controller (master) drives the motor commands and observes the
// cabin status; the cabin responder (slave) does the opposite.
//   motorsubir, motorbajar : up / down motor commands
//   dato                   : current floor code (1..NUM_FLOORS)
//   en_piso                : cabin stopped at a floor
//   moviendo               : cabin travelling up or down
//   llegada                : one-cycle arrival pulse
//   falla                  : sticky fault flag
interface elevador_cabina_if;
    logic       motorsubir;
    logic       motorbajar;
    logic [3:0] dato;
    logic       en_piso;
    logic       moviendo;
    logic       llegada;
    logic       falla;

    modport master (
        output motorsubir,
        output motorbajar,
        input  dato,
        input  en_piso,
        input  moviendo,
        input  llegada,
        input  falla
    );

    modport slave (
        input  motorsubir,
        input  motorbajar,
        output dato,
        output en_piso,
        output moviendo,
        output llegada,
        output falla
    );
endinterface

// File: rtl/elevador_cabina.sv
// Cabin/shaft-side responder for the elevator controller.
// Counts travel ticks while a motor command is held, reports the current
// floor and motion status, pulses llegada on arrival and latches a sticky
// fault on illegal commands (both motors, overtravel, reversal mid-travel).
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous reset, active low
//   bus   : slave side of elevador_cabina_if (motor inputs, status outputs)
// All outputs are registered and updated together with the state, so they
// always describe the state the FSM has just entered.
module elevador_cabina #(
    parameter int TRAVEL_TICKS = 4,   // edges per floor, 1..255
    parameter int NUM_FLOORS   = 3    // highest floor, 2..15
) (
    input  logic               clk,
    input  logic               rst_n,
    elevador_cabina_if.slave   bus
);

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        SUBIENDO = 2'd1,
        BAJANDO  = 2'd2,
        FALLA    = 2'd3
    } state_t;

    localparam logic [3:0] TOP_FLOOR   = 4'(NUM_FLOORS);
    localparam logic [7:0] LAST_TICK   = 8'(TRAVEL_TICKS - 1);
    localparam bit         SINGLE_TICK = (TRAVEL_TICKS == 1);

    state_t     state_reg;
    logic [3:0] piso_reg;
    logic [7:0] cnt_reg;
    logic       en_piso_reg;
    logic       moviendo_reg;
    logic       llegada_reg;
    logic       falla_reg;

    logic sub;
    logic baj;
    assign sub = bus.motorsubir;
    assign baj = bus.motorbajar;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= PARADO;
            piso_reg     <= 4'd1;
            cnt_reg      <= 8'd0;
            en_piso_reg  <= 1'b1;
            moviendo_reg <= 1'b0;
            llegada_reg  <= 1'b0;
            falla_reg    <= 1'b0;
        end else begin
            llegada_reg <= 1'b0;
            case (state_reg)
                PARADO: begin
                    if ((sub && baj) || (sub && piso_reg == TOP_FLOOR) ||
                        (baj && piso_reg == 4'd1)) begin
                        // Conflicting command or overtravel at either end.
                        state_reg    <= FALLA;
                        falla_reg    <= 1'b1;
                        en_piso_reg  <= 1'b0;
                        moviendo_reg <= 1'b0;
                    end else if (sub) begin
                        if (SINGLE_TICK) begin
                            // One tick per floor: arrive without leaving PARADO.
                            piso_reg    <= piso_reg + 4'd1;
                            llegada_reg <= 1'b1;
                        end else begin
                            state_reg    <= SUBIENDO;
                            cnt_reg      <= 8'd1;
                            en_piso_reg  <= 1'b0;
                            moviendo_reg <= 1'b1;
                        end
                    end else if (baj) begin
                        if (SINGLE_TICK) begin
                            piso_reg    <= piso_reg - 4'd1;
                            llegada_reg <= 1'b1;
                        end else begin
                            state_reg    <= BAJANDO;
                            cnt_reg      <= 8'd1;
                            en_piso_reg  <= 1'b0;
                            moviendo_reg <= 1'b1;
                        end
                    end
                end
                SUBIENDO: begin
                    if (baj) begin
                        // Reversal (or both) mid-travel; piso stays at the departed floor.
                        state_reg    <= FALLA;
                        falla_reg    <= 1'b1;
                        en_piso_reg  <= 1'b0;
                        moviendo_reg <= 1'b0;
                    end else if (sub) begin
                        if (cnt_reg == LAST_TICK) begin
                            state_reg    <= PARADO;
                            piso_reg     <= piso_reg + 4'd1;
                            cnt_reg      <= 8'd0;
                            llegada_reg  <= 1'b1;
                            en_piso_reg  <= 1'b1;
                            moviendo_reg <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg + 8'd1;
                        end
                    end
                    // Motor released: stall between floors, everything held.
                end
                BAJANDO: begin
                    if (sub) begin
                        state_reg    <= FALLA;
                        falla_reg    <= 1'b1;
                        en_piso_reg  <= 1'b0;
                        moviendo_reg <= 1'b0;
                    end else if (baj) begin
                        if (cnt_reg == LAST_TICK) begin
                            state_reg    <= PARADO;
                            piso_reg     <= piso_reg - 4'd1;
                            cnt_reg      <= 8'd0;
                            llegada_reg  <= 1'b1;
                            en_piso_reg  <= 1'b1;
                            moviendo_reg <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg + 8'd1;
                        end
                    end
                end
                default: begin
                    // FALLA is absorbing until reset; outputs already frozen.
                end
            endcase
        end
    end

    assign bus.dato     = piso_reg;
    assign bus.en_piso  = en_piso_reg;
    assign bus.moviendo = moviendo_reg;
    assign bus.llegada  = llegada_reg;
    assign bus.falla    = falla_reg;

endmodule

// File: tb/tb_elevador_cabina.sv
// Scoreboard bench for elevador_cabina: stimulus pushes the expected status
// after each edge into a queue, a negedge monitor pops and compares.
// Instance u0 uses TRAVEL_TICKS=4, instance u1 uses TRAVEL_TICKS=1.
module tb_elevador_cabina;

    logic clk;
    logic rst_n;

    elevador_cabina_if bus0 ();
    elevador_cabina_if bus1 ();

    elevador_cabina #(.TRAVEL_TICKS(4), .NUM_FLOORS(3)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    elevador_cabina #(.TRAVEL_TICKS(1), .NUM_FLOORS(3)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         dut;
        string      nm;
        logic [7:0] v;   // {dato, en_piso, moviendo, llegada, falla}
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    // Monitor: status registered at posedge is compared at the next negedge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t       e;
            logic [7:0] act;
            e = q.pop_front();
            if (e.dut == 0)
                act = {bus0.dato, bus0.en_piso, bus0.moviendo, bus0.llegada, bus0.falla};
            else
                act = {bus1.dato, bus1.en_piso, bus1.moviendo, bus1.llegada, bus1.falla};
            checks = checks + 1;
            if (act !== e.v)
                $display("FAIL %s: got dato=%0d en=%b mv=%b ll=%b fa=%b, want dato=%0d en=%b mv=%b ll=%b fa=%b",
                         e.nm, act[7:4], act[3], act[2], act[1], act[0],
                         e.v[7:4], e.v[3], e.v[2], e.v[1], e.v[0]);
            else begin
                passed = passed + 1;
                $display("ok   %s: dato=%0d en=%b mv=%b ll=%b fa=%b",
                         e.nm, act[7:4], act[3], act[2], act[1], act[0]);
            end
        end
    end

    // One edge: drive inputs on the selected DUT (other DUT idle), expect status.
    task automatic step(input int d, input bit rn, input bit s, input bit b,
                        input int ed, input bit een, input bit emv,
                        input bit ell, input bit efa, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n           = rn;
        bus0.motorsubir = (d == 0) ? s : 1'b0;
        bus0.motorbajar = (d == 0) ? b : 1'b0;
        bus1.motorsubir = (d == 1) ? s : 1'b0;
        bus1.motorbajar = (d == 1) ? b : 1'b0;
        @(posedge clk);
        #1;
        e.dut = d;
        e.nm  = nm;
        e.v   = {4'(ed), een, emv, ell, efa};
        q.push_back(e);
    endtask

    // Hold one motor for four edges from a stopped floor: travel then arrive.
    task automatic move4(input bit up, input int from, input string nm);
        int to;
        to = up ? from + 1 : from - 1;
        for (int i = 1; i <= 3; i++)
            step(0, 1, up, !up, from, 0, 1, 0, 0, nm);
        step(0, 1, up, !up, to, 1, 0, 1, 0, {nm, "_arrive"});
    endtask

    initial begin
        rst_n = 1'b0;
        bus0.motorsubir = 1'b0;
        bus0.motorbajar = 1'b0;
        bus1.motorsubir = 1'b0;
        bus1.motorbajar = 1'b0;

        step(0, 0, 0, 0, 1, 1, 0, 0, 0, "reset");
        step(0, 1, 0, 0, 1, 1, 0, 0, 0, "idle_f1");

        // Continuous up from 1 to 3: two arrivals, 4 edges each.
        move4(1, 1, "up_1to2");
        move4(1, 2, "up_2to3");
        step(0, 1, 0, 0, 3, 1, 0, 0, 0, "idle_f3");

        // Down 3 -> 2, then back up to 3.
        move4(0, 3, "down_3to2");
        step(0, 1, 0, 0, 2, 1, 0, 0, 0, "idle_f2");
        move4(1, 2, "up_2to3b");

        // Overtravel up at top floor: fault, frozen, inputs ignored.
        step(0, 1, 1, 0, 3, 0, 0, 0, 1, "overtravel_up");
        step(0, 1, 0, 1, 3, 0, 0, 0, 1, "falla_hold_baj");
        step(0, 1, 1, 1, 3, 0, 0, 0, 1, "falla_hold_both");
        step(0, 1, 0, 0, 3, 0, 0, 0, 1, "falla_hold_idle");

        // Reset out of FALLA, motor asserted alongside: no arrival pulse.
        step(0, 0, 1, 0, 1, 1, 0, 0, 0, "reset_in_falla");

        // Stall: 2 high, 3 low, 2 high -> arrival on 7th edge.
        step(0, 1, 1, 0, 1, 0, 1, 0, 0, "stall_h1");
        step(0, 1, 1, 0, 1, 0, 1, 0, 0, "stall_h2");
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 0, 1, 0, 1, 0, 0, "stall_low");
        step(0, 1, 1, 0, 1, 0, 1, 0, 0, "stall_h3");
        step(0, 1, 1, 0, 2, 1, 0, 1, 0, "stall_arrive");
        step(0, 1, 0, 0, 2, 1, 0, 0, 0, "stall_after");

        // Reversal during SUBIENDO with cnt=2.
        step(0, 1, 1, 0, 2, 0, 1, 0, 0, "rev_up1");
        step(0, 1, 1, 0, 2, 0, 1, 0, 0, "rev_up2");
        step(0, 1, 0, 1, 2, 0, 0, 0, 1, "rev_fault");
        step(0, 0, 0, 0, 1, 1, 0, 0, 0, "reset_rev");

        // Both motors in PARADO.
        step(0, 1, 1, 1, 1, 0, 0, 0, 1, "both_parado");
        step(0, 0, 0, 0, 1, 1, 0, 0, 0, "reset_both");

        // Overtravel down at floor 1.
        step(0, 1, 0, 1, 1, 0, 0, 0, 1, "overtravel_down");
        step(0, 0, 0, 0, 1, 1, 0, 0, 0, "reset_down");

        // Reset during BAJANDO.
        move4(1, 1, "up_for_down");
        step(0, 1, 0, 1, 2, 0, 1, 0, 0, "bajando1");
        step(0, 1, 0, 1, 2, 0, 1, 0, 0, "bajando2");
        step(0, 0, 0, 1, 1, 1, 0, 0, 0, "reset_bajando");
        step(0, 1, 0, 0, 1, 1, 0, 0, 0, "idle_after_rst");

        // TRAVEL_TICKS=1 instance: each edge moves one floor from PARADO.
        step(1, 0, 0, 0, 1, 1, 0, 0, 0, "tt1_reset");
        step(1, 1, 1, 0, 2, 1, 0, 1, 0, "tt1_up1");
        step(1, 1, 1, 0, 3, 1, 0, 1, 0, "tt1_up2");
        step(1, 1, 0, 0, 3, 1, 0, 0, 0, "tt1_idle");
        step(1, 1, 0, 1, 2, 1, 0, 1, 0, "tt1_down");
        step(1, 1, 0, 0, 2, 1, 0, 0, 0, "tt1_idle2");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge clk);
        #2;
        if (q.size() > 0) begin
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
            checks = checks + 1;
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/elevador_cabina.md
Name: elevador_cabina

Overview:
- Cabin/shaft-side responder for the elevator controller: consumes the motor commands (motorsubir, motorbajar) and produces the floor code (dato) that drives the controller's 7-segment decoder.
- Counts travel ticks while a motor command is active and reports the current floor, arrival and motion status.
- Latches a sticky fault on illegal commands.
- Sits between the controller FSM and the display path at TinyTapeout top level; replaces the bench stimulus on dato.

Parameters:
- TRAVEL_TICKS, 4, number of clock edges with the motor command high needed to move one floor; legal range 1..255.
- NUM_FLOORS, 3, highest floor number; floors are numbered 1..NUM_FLOORS; legal range 2..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- motorsubir  in  1  up command from the controller.
- motorbajar  in  1  down command from the controller.
- dato  out  4  current floor code, binary 1..NUM_FLOORS; holds the last departed floor while travelling.
- en_piso  out  1  high when the cabin is stopped at a floor.
- moviendo  out  1  high while in SUBIENDO or BAJANDO.
- llegada  out  1  one-cycle pulse on arrival at a new floor.
- falla  out  1  sticky fault flag.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - state=PARADO, piso=1, dato=4'd1, cnt=0.
  - en_piso=1, moviendo=0, llegada=0, falla=0.
  - Reset overrides everything, including mid-travel and FALLA; the cabin returns to floor 1 with no arrival pulse.
- Register and width rules:
  - All outputs are registered; no combinational path from motor inputs to outputs.
  - cnt width is 8 bits.
  - piso is 4 bits; dato = piso.
- States: PARADO, SUBIENDO, BAJANDO, FALLA.
- Per-edge rules, default llegada=0:
  - PARADO:
    - both motor inputs high -> FALLA.
    - motorsubir only, piso==NUM_FLOORS -> FALLA (overtravel up).
    - motorbajar only, piso==1 -> FALLA (overtravel down).
    - motorsubir only, legal -> if TRAVEL_TICKS==1: piso+1, llegada=1, stay PARADO; else SUBIENDO, cnt=1.
    - motorbajar only, legal -> symmetric: if TRAVEL_TICKS==1: piso-1, llegada=1, stay PARADO; else BAJANDO, cnt=1.
    - neither -> hold.
  - SUBIENDO:
    - motorbajar high (alone or with subir) -> FALLA.
    - motorsubir high and cnt==TRAVEL_TICKS-1 -> piso+1, cnt=0, llegada=1, PARADO.
    - motorsubir high otherwise -> cnt+1.
    - motorsubir low -> stall: hold cnt and state, cabin stays between floors, resumes on next high.
  - BAJANDO: mirror of SUBIENDO, with the roles of motorsubir and motorbajar swapped and piso-1 on arrival.
  - FALLA:
    - absorbing; ignores all inputs; piso and dato frozen at their fault-entry values.
    - falla=1, en_piso=0, moviendo=0.
    - exit only via reset.
- Output decode: registered from the next state, so outputs are valid the same cycle the state changes.
  - en_piso=1 only in PARADO.
  - moviendo=1 in SUBIENDO or BAJANDO.
  - llegada is high for exactly one cycle, coincident with dato showing the new floor and en_piso=1.
- Latency: from the first edge sampling motorsubir=1 in PARADO, arrival is visible after exactly TRAVEL_TICKS sampled-high edges; stall cycles add 1:1.
- Overtravel check applies only from PARADO. Mid-travel arrival cannot exceed the limits, because departure was legal.

Test Plan:
- Reset with TRAVEL_TICKS=4 -> dato=1, en_piso=1, moviendo=0, llegada=0, falla=0.
- motorsubir=1 held for 4 edges from floor 1 -> moviendo=1 after edge 1; on edge 4 dato=2, llegada=1 for one cycle, en_piso=1. Hold 4 more edges -> dato=3.
- From floor 1: motorsubir 2 edges high, 3 low, 2 high -> arrival on the 7th edge, dato=2.
- At floor 3: motorbajar 4 edges -> dato=2, llegada pulse. Then motorsubir=1 at floor 3 -> falla=1, en_piso=0, dato frozen at 3; further inputs ignored.
- During SUBIENDO with cnt=2, assert motorbajar -> falla=1 next edge, dato unchanged. Both motors high in PARADO -> falla=1.
- rst_n=0 during BAJANDO and during FALLA -> next edge dato=1, falla=0, en_piso=1, no llegada. Separately, with TRAVEL_TICKS=1, a single motorsubir edge -> dato=2, llegada=1 without visiting SUBIENDO.
